// File: rtl/popcount_sched.sv
// -----------------------------------------------------------------------------
// popcount_sched
//
// Round-robin scheduler in front of a single shared ones-counter. Up to N_REQ
// requesters present WIDTH-bit words. One word is accepted at a time. Its bit
// count is returned on a valid/ready result port, tagged with the index of the
// requester that supplied it.
//
// Ports
//   clk_i       rising-edge clock
//   srst_i      asynchronous, active-high reset
//   req_val_i   per-requester word valid
//   req_data_i  requester k word at [k*WIDTH +: WIDTH]
//   req_rdy_o   one-hot-or-zero grant; a word is accepted when val & rdy
//   res_val_o   result valid (held until res_rdy_i)
//   res_rdy_i   downstream ready
//   res_id_o    requester index of the result
//   res_data_o  number of '1' bits in the accepted word
// -----------------------------------------------------------------------------
module popcount_sched #(
    parameter  int WIDTH = 8,
    parameter  int N_REQ = 4,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [N_REQ-1:0]       req_val_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_rdy_o,
    output logic                   res_val_o,
    input  logic                   res_rdy_i,
    output logic [IW-1:0]          res_id_o,
    output logic [CW-1:0]          res_data_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;  // engine free
    localparam logic [1:0] ST_CALC = 2'd1;  // word latched, count settling
    localparam logic [1:0] ST_DONE = 2'd2;  // result held for downstream

    logic [1:0]       state_q,      state_d;
    logic [IW-1:0]    last_grant_q, last_grant_d;
    logic [WIDTH-1:0] word_q,       word_d;
    logic [IW-1:0]    id_q,         id_d;
    logic [CW-1:0]    res_data_q,   res_data_d;

    logic             grant_en;
    logic             found;
    logic             accept;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    cand;
    logic [CW-1:0]    ones;

    // Index offset 'off' positions after 'base', wrapping at N_REQ (N_REQ need
    // not be a power of two).
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % N_REQ;
        return IW'(sum);
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin grant. Depends only on state, res_rdy_i, req_val_i and
    // last_grant_q, never on request data. Reset forces the grant low even
    // though the state flops are already cleared, so no accept can be seen
    // while reset is held.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        grant_en  = !srst_i && ((state_q == ST_IDLE) ||
                                ((state_q == ST_DONE) && res_rdy_i));
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_rdy_o = '0;
        // Search starts one past the last winner, so the winner drops to
        // lowest priority and nobody waits more than N_REQ grants.
        for (int i = 1; i <= N_REQ; i++) begin
            cand = rr_idx(last_grant_q, i);
            if (!found && req_val_i[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        accept = grant_en && found;
        if (accept) begin
            req_rdy_o[grant_idx] = 1'b1;
        end
    end

    // Ones-count of the latched word, zero-extended into CW bits.
    always_comb begin
        ones = '0;
        for (int b = 0; b < WIDTH; b++) begin
            ones = ones + CW'(word_q[b]);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        word_d       = word_q;
        id_d         = id_q;
        res_data_d   = res_data_q;

        // Priority pointer moves only on a real accept. A withdrawn request
        // therefore leaves the rotation untouched.
        if (accept) begin
            word_d       = req_data_i[grant_idx*WIDTH +: WIDTH];
            id_d         = grant_idx;
            last_grant_d = grant_idx;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_CALC;
            end
            ST_CALC: begin
                res_data_d = ones;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                // Accepting during the transfer cycle goes straight back to
                // CALC, so there is no IDLE bubble.
                if (res_rdy_i) state_d = accept ? ST_CALC : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(N_REQ - 1);  // requester 0 wins first
            word_q       <= '0;
            id_q         <= '0;
            res_data_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            word_q       <= word_d;
            id_q         <= id_d;
            res_data_q   <= res_data_d;
        end
    end

    assign res_val_o  = (state_q == ST_DONE);
    assign res_id_o   = id_q;
    assign res_data_o = res_data_q;

endmodule

// File: doc/popcount_sched.md
# popcount_sched

Shared-resource scheduler for the team's population-count datapath. Up to N_REQ requesters each present a WIDTH-bit word. The block arbitrates between them round-robin and drives the single embedded count engine (registered input, combinational ones-count). It returns each result tagged with the requester index through a valid/ready output port. It sits between multiple packet-field extractors and the statistics logic, so only one ones-counter is needed.

## Interface
- WIDTH, 8, bits per input word (≥2)
- N_REQ, 4, number of requesters (≥2)
- CW, $clog2(WIDTH+1) (derived localparam), result width; must hold the value WIDTH
- IW, $clog2(N_REQ) (derived localparam), requester-index width
- clk_i  in  1  single clock, all logic on rising edge
- srst_i  in  1  reset, asynchronous, active-high
- req_val_i  in  N_REQ  per-requester word valid
- req_data_i  in  N_REQ*WIDTH  requester k word at bits [k*WIDTH +: WIDTH]
- req_rdy_o  out  N_REQ  one-hot-or-zero grant; accept when req_val_i[k] & req_rdy_o[k]
- res_val_o  out  1  result valid
- res_rdy_i  in  1  downstream ready
- res_id_o  out  IW  index of requester whose word produced the result
- res_data_o  out  CW  number of '1' bits in the accepted word

## Operation
- FSM states:
  - IDLE: engine free.
  - CALC: word latched, count settling.
  - DONE: result held.
- Transitions:
  - IDLE→CALC on any accept.
  - CALC→DONE unconditionally.
  - DONE→IDLE on res_rdy_i with no accept.
  - DONE→CALC on res_rdy_i with a simultaneous accept (bypass).
  - DONE stays DONE while res_rdy_i=0.
- Grant is asserted only in IDLE, or in DONE with res_rdy_i=1; otherwise req_rdy_o=0.
- Grant selection is round-robin:
  - Search starts at (last_grant+1) mod N_REQ and wraps.
  - The first k with req_val_i[k]=1 gets req_rdy_o[k]=1.
  - At most one bit of req_rdy_o is set.
- req_rdy_o is combinational from state, res_rdy_i, req_val_i and last_grant. It must not depend on req_data_i.
- last_grant updates to k only on an accept. A requester that drops req_val_i before acceptance loses nothing and gains no priority.
- On accept:
  - Latch req_data_i[k] into the engine input register.
  - Latch k into the id register.
- In CALC, the ones-count of the latched word is written into the res_data_o register. The sum is zero-extended, so no overflow is possible: max value WIDTH fits CW bits.
- In DONE, res_val_o=1 and res_data_o/res_id_o are held stable until res_rdy_i=1.
- Requesters must hold req_data_i stable only in the accept cycle. The block has no other dependency on requester data.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, last_grant=N_REQ-1, so requester 0 has first priority.
  - res_val_o=0, res_id_o=0, res_data_o=0.
  - req_rdy_o=0 while srst_i=1.
- Latency: accept in cycle T → CALC in T+1 → res_val_o=1 from T+2.
- Result transfer occurs on the edge where res_val_o & res_rdy_i.
- Throughput: one result per 2 cycles with res_rdy_i tied high (accept T, T+2, T+4 …). Bypass from DONE avoids an IDLE bubble.
- Backpressure: with res_rdy_i=0, results are held indefinitely and no new accepts occur (all req_rdy_o=0).
- Simultaneous requests are served in strict rotation. No requester waits more than N_REQ grants.
- Reset asserted mid-operation (CALC or DONE):
  - Any in-flight word is discarded.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - No result is emitted for that word after release.
- A word of all zeros produces res_data_o=0, and that result is still delivered with res_val_o=1.

## Test plan
- Single request, WIDTH=8, N_REQ=4: req 2, data 0xA5 → req_rdy_o=0b0100 in the same cycle; res_val_o=1 two cycles later with res_id_o=2, res_data_o=4.
- Boundary values: 0xFF from req 0 → res_data_o=8 (4-bit CW correct). 0x00 → res_data_o=0, still valid.
- Round-robin fairness: all four req_val_i held high, res_rdy_i=1, distinct data.
  - Grant order is 0,1,2,3,0,…
  - Accepts occur every 2 cycles.
  - Each id is returned with the matching count.
- Backpressure: res_rdy_i=0 for 5 cycles after res_val_o rises.
  - res_val_o, res_id_o and res_data_o stay constant.
  - req_rdy_o=0 throughout.
  - Raising res_rdy_i with req 3 pending gives bypass to CALC, with the next result 2 cycles later.
- Async reset mid-CALC (not edge-aligned):
  - res_val_o=0 and req_rdy_o=0 immediately.
  - After release, the first grant goes to req 0.
  - The discarded word is never output.
- Withdrawn request: req 1 raises req_val_i while engine busy, drops it before a grant.
  - No accept for req 1.
  - last_grant unchanged.
  - Next grant follows rotation from the previous winner.
